// File: rtl/ysyx_22040750_defs.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040750_defs : CLINT register offsets, bus FSM states, byte merge  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package ysyx_22040750_defs;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [31:0] WINDOW_SIZE  = 32'h0001_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040750_clint_timer.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040750_clint_timer : prescaled mtime, mtimecmp, registered MTIP   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ysyx_22040750_clint_timer
  import ysyx_22040750_defs::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_wr_mtime,
  input  logic        I_wr_mtimecmp,
  input  logic [63:0] I_wdata,
  input  logic [7:0]  I_wstrb,
  output logic [63:0] O_mtime,
  output logic [63:0] O_mtimecmp,
  output logic        O_mtip
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRESC_W-1:0] r_presc;
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic               r_mtip;
  logic               w_tick;

  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  // The prescaler free-runs; software writes to mtime never realign it.
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      r_presc    <= '0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_mtip     <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (I_wr_mtime)
        r_mtime <= byte_merge(r_mtime, I_wdata, I_wstrb);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
      if (I_wr_mtimecmp)
        r_mtimecmp <= byte_merge(r_mtimecmp, I_wdata, I_wstrb);
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  assign O_mtime    = r_mtime;
  assign O_mtimecmp = r_mtimecmp;
  assign O_mtip     = r_mtip;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040750_clint.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040750_clint : CLINT MMIO slave (bus FSM, decode, msip)           |
// | Optional msip register enabled by CLINT_MSIP_EN.  Revision 1.0           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ysyx_22040750_clint
  import ysyx_22040750_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic        I_req_wen,
  input  logic [31:0] I_req_addr,
  input  logic [63:0] I_req_wdata,
  input  logic [7:0]  I_req_wstrb,
  output logic        O_rsp_valid,
  input  logic        I_rsp_ready,
  output logic [63:0] O_rsp_rdata,
  output logic        O_rsp_err,
  output logic        O_mtip,
  output logic        O_msip
);

  clint_state_e r_state;
  logic         r_rsp_valid;
  logic [63:0]  r_rdata;
  logic         r_err;

  logic [31:0]  w_offset;
  logic         w_in_win;
  logic         w_hit_msip;
  logic         w_hit_cmp;
  logic         w_hit_mtime;
  logic         w_mapped;
  logic         w_accept;
  logic         w_msip;
  logic [63:0]  w_rdata;
  logic [63:0]  w_mtime;
  logic [63:0]  w_mtimecmp;

  assign w_offset    = I_req_addr - BASE_ADDR;
  assign w_in_win    = (I_req_addr >= BASE_ADDR) && (w_offset < WINDOW_SIZE);
  assign w_hit_msip  = w_in_win && (w_offset[15:3] == MSIP_OFF[15:3]);
  assign w_hit_cmp   = w_in_win && (w_offset[15:3] == MTIMECMP_OFF[15:3]);
  assign w_hit_mtime = w_in_win && (w_offset[15:3] == MTIME_OFF[15:3]);
  assign w_accept    = I_req_valid && (r_state == IDLE);

`ifdef CLINT_MSIP_EN
  localparam logic MSIP_EN = 1'b1;
  logic r_msip;

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst)
      r_msip <= 1'b0;
    else if (w_accept && I_req_wen && w_hit_msip && I_req_wstrb[0])
      r_msip <= I_req_wdata[0];
  end

  assign w_msip = r_msip;
`else
  localparam logic MSIP_EN = 1'b0;
  assign w_msip = 1'b0;
`endif

  assign w_mapped = w_hit_cmp || w_hit_mtime || (MSIP_EN && w_hit_msip);

  always_comb begin
    w_rdata = 64'd0;
    if (w_hit_mtime)                w_rdata = w_mtime;
    else if (w_hit_cmp)             w_rdata = w_mtimecmp;
    else if (MSIP_EN && w_hit_msip) w_rdata = {63'd0, w_msip};
  end

  ysyx_22040750_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .I_sys_clk     (I_sys_clk),
    .I_rst         (I_rst),
    .I_wr_mtime    (w_accept && I_req_wen && w_hit_mtime),
    .I_wr_mtimecmp (w_accept && I_req_wen && w_hit_cmp),
    .I_wdata       (I_req_wdata),
    .I_wstrb       (I_req_wstrb),
    .O_mtime       (w_mtime),
    .O_mtimecmp    (w_mtimecmp),
    .O_mtip        (O_mtip)
  );

  // Response payload is captured at accept and held until the LSU takes it.
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 64'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (I_req_valid) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= I_req_wen ? 64'd0 : w_rdata;
            r_err       <= ~w_mapped;
          end
        end
        RESP: begin
          if (I_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign O_req_ready = (r_state == IDLE);
  assign O_rsp_valid = r_rsp_valid;
  assign O_rsp_rdata = r_rdata;
  assign O_rsp_err   = r_err;
  assign O_msip      = w_msip;

endmodule

`default_nettype wire
